cm0_pmu_seq: RTL and testbench
==============================

CM0_PMU_SEQ -- requirements
Module: cm0_pmu_seq

Interface
REQ-001 Parameter: HOLDTO, 15, max cycles waited for SLEEPHOLDACKn low before abort (range 1..255).
REQ-002 Parameter: DBGSYNC, 2, synchroniser depth for CDBGPWRUPREQ to CDBGPWRUPACK (range 2..3).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 FCLK  in  1  free-running clock; all state on rising edge.
REQ-005 PORESET  in  1  asynchronous active-high reset.
REQ-006 SLEEPING  in  1  core sleep indication.
REQ-007 SLEEPDEEP  in  1  core deep-sleep indication.
REQ-008 GATEHCLK  in  1  core permits HCLK gating.
REQ-009 WAKEUP  in  1  wake request from core/WIC.
REQ-010 SLEEPHOLDACKn  in  1  core hold acknowledge, active-low.
REQ-011 WICENACK  in  1  WIC enable acknowledge.
REQ-012 CDBGPWRUPREQ  in  1  debug power-up request.
REQ-013 DEEPEN  in  1  software enable for WIC deep sleep.
REQ-014 WAKEDLY  in  4  cycles HCLK runs before hold release on wake.
REQ-015 HCLKEN  out  1  HCLK gate enable, registered.
REQ-016 SLEEPHOLDREQn  out  1  hold request to core, active-low, registered.
REQ-017 WICENREQ  out  1  WIC enable request, registered.
REQ-018 CDBGPWRUPACK  out  1  debug power-up acknowledge.
REQ-019 PMUSTATE  out  2  current state: 0 RUN, 1 HOLD, 2 GATED, 3 WAKE.
REQ-020 GATEDCNT  out  16  count of cycles spent in GATED, saturating.
REQ-021 HOLDABORT  out  1  sticky flag, set on hold timeout/abort.

Function
REQ-022 WICENREQ SHALL equal DEEPEN delayed one FCLK cycle.
REQ-023 CDBGPWRUPACK SHALL equal CDBGPWRUPREQ delayed DBGSYNC cycles via flop chain; dbg_on = CDBGPWRUPREQ | CDBGPWRUPACK.
REQ-024 sleep_ok = SLEEPING & GATEHCLK & ~dbg_on & (~SLEEPDEEP | WICENACK).
REQ-025 RUN: HCLKEN=1, SLEEPHOLDREQn=1; sleep_ok -> HOLD next cycle, hold counter cleared.
REQ-026 HOLD: SLEEPHOLDREQn=0, HCLKEN=1, counter increments each cycle.
REQ-027 HOLD priority: (1) WAKEUP|~SLEEPING|dbg_on -> RUN, HOLDABORT=1; (2) SLEEPHOLDACKn=0 -> GATED; (3) counter==HOLDTO-1 -> RUN, HOLDABORT=1.
REQ-028 GATED: HCLKEN=0, SLEEPHOLDREQn=0; WAKEUP|dbg_on -> WAKE, wake counter loaded with WAKEDLY.
REQ-029 GATED SHALL increment GATEDCNT every cycle, holding at 16'hFFFF; GATEDCNT never clears except by reset.
REQ-030 WAKE: HCLKEN=1, SLEEPHOLDREQn=0; counter decrements each cycle; counter==0 -> RUN (WAKEDLY=0 gives one WAKE cycle).
REQ-031 WAKE SHALL NOT be interrupted by any input; re-entry into HOLD requires passing through RUN for at least one cycle.
REQ-032 HCLKEN and SLEEPHOLDREQn SHALL be decoded from next-state and registered, so they change on the same edge as PMUSTATE.
REQ-033 HOLDABORT SHALL remain 1 until reset once set.
REQ-034 Input changes of SLEEPDEEP/WICENACK while GATED SHALL have no effect.

Reset
REQ-035 On PORESET=1, asynchronously: PMUSTATE=RUN, HCLKEN=1, SLEEPHOLDREQn=1, WICENREQ=0, CDBGPWRUPACK=0 (and sync chain 0), GATEDCNT=0, HOLDABORT=0, counters 0.
REQ-036 Reset asserted in GATED or HOLD SHALL restore HCLKEN=1 and SLEEPHOLDREQn=1 without waiting for a clock edge.

Verification
REQ-037 Normal sleep: SLEEPING=GATEHCLK=1, SLEEPDEEP=0, ack low 3 cycles later -> HOLD, then GATED, HCLKEN=0; WAKEUP pulse with WAKEDLY=4 -> 5 WAKE cycles with HCLKEN=1, then RUN, SLEEPHOLDREQn=1.
REQ-038 Deep sleep gating: SLEEPDEEP=1, WICENACK=0 -> stays RUN; WICENACK=1 -> HOLD next cycle.
REQ-039 Timeout: HOLDTO=15, SLEEPHOLDACKn held 1 -> return to RUN after 15 HOLD cycles, HOLDABORT=1.
REQ-040 Debug: CDBGPWRUPREQ=1 while GATED -> WAKE next cycle; CDBGPWRUPACK=1 after 2 cycles; no re-entry to HOLD while dbg_on.
REQ-041 Saturation: force 70000 GATED cycles -> GATEDCNT=16'hFFFF.
REQ-042 Reset mid-GATED: PORESET pulse -> HCLKEN=1, SLEEPHOLDREQn=1, GATEDCNT=0 immediately.

Source files
------------

// File: rtl/cm0_pmu_seq_if.sv
// Core/WIC-facing handshake bundle for the Cortex-M0 power-management sequencer.
// The slave modport is the sequencer. The master modport is the core/WIC side that drives it.
`timescale 1ns/1ps
interface cm0_pmu_seq_if;
   logic        SLEEPING;
   logic        SLEEPDEEP;
   logic        GATEHCLK;
   logic        WAKEUP;
   logic        SLEEPHOLDACKn;
   logic        WICENACK;
   logic        CDBGPWRUPREQ;
   logic        DEEPEN;
   logic [3:0]  WAKEDLY;
   logic        HCLKEN;
   logic        SLEEPHOLDREQn;
   logic        WICENREQ;
   logic        CDBGPWRUPACK;
   logic [1:0]  PMUSTATE;
   logic [15:0] GATEDCNT;
   logic        HOLDABORT;

   modport slave (
      input  SLEEPING, SLEEPDEEP, GATEHCLK, WAKEUP, SLEEPHOLDACKn, WICENACK,
             CDBGPWRUPREQ, DEEPEN, WAKEDLY,
      output HCLKEN, SLEEPHOLDREQn, WICENREQ, CDBGPWRUPACK, PMUSTATE,
             GATEDCNT, HOLDABORT
   );

   modport master (
      output SLEEPING, SLEEPDEEP, GATEHCLK, WAKEUP, SLEEPHOLDACKn, WICENACK,
             CDBGPWRUPREQ, DEEPEN, WAKEDLY,
      input  HCLKEN, SLEEPHOLDREQn, WICENREQ, CDBGPWRUPACK, PMUSTATE,
             GATEDCNT, HOLDABORT
   );
endinterface

// File: rtl/cm0_pmu_seq.sv
// Cortex-M0 sleep/HCLK-gating sequencer: hold handshake, clock gating, timed wake, debug keep-alive.
//  state   | meaning
//  s_run   | core running, HCLK on, no hold requested
//  s_hold  | hold requested, waiting for SLEEPHOLDACKn (bounded by HOLDTO)
//  s_gated | HCLK gated, waiting for wake or debug request
//  s_wake  | HCLK on for WAKEDLY+1 cycles before the hold is released
`timescale 1ns/1ps
module cm0_pmu_seq #(
   parameter int HOLDTO  = 15,
   parameter int DBGSYNC = 2
) (
   input logic          FCLK,
   input logic          PORESET,
   cm0_pmu_seq_if.slave pmu
);

   typedef enum logic [1:0] {
      s_run   = 2'd0,
      s_hold  = 2'd1,
      s_gated = 2'd2,
      s_wake  = 2'd3
   } state_t;

   localparam logic [7:0] hold_last = 8'(HOLDTO - 1);

   state_t             state;
   logic [7:0]         cnt;
   logic [DBGSYNC-1:0] dbg_sync;
   logic               dbg_on;
   logic               sleep_ok;

   assign pmu.CDBGPWRUPACK = dbg_sync[DBGSYNC-1];
   assign pmu.PMUSTATE     = state;
   assign dbg_on   = pmu.CDBGPWRUPREQ | pmu.CDBGPWRUPACK;
   assign sleep_ok = pmu.SLEEPING & pmu.GATEHCLK & ~dbg_on &
                     (~pmu.SLEEPDEEP | pmu.WICENACK);

   always_ff @(posedge FCLK or posedge PORESET) begin
      if (PORESET) begin
         dbg_sync     <= '0;
         pmu.WICENREQ <= 1'b0;
      end else begin
         dbg_sync     <= {dbg_sync[DBGSYNC-2:0], pmu.CDBGPWRUPREQ};
         pmu.WICENREQ <= pmu.DEEPEN;
      end
   end

   always_ff @(posedge FCLK or posedge PORESET) begin
      if (PORESET) begin
         pmu.GATEDCNT <= 16'h0000;
      end else if (state == s_gated && pmu.GATEDCNT != 16'hFFFF) begin
         pmu.GATEDCNT <= pmu.GATEDCNT + 16'h0001;
      end
   end

   // Outputs are assigned alongside the state so they follow the next state on the same edge.
   always_ff @(posedge FCLK or posedge PORESET) begin
      if (PORESET) begin
         state             <= s_run;
         cnt               <= 8'h00;
         pmu.HCLKEN        <= 1'b1;
         pmu.SLEEPHOLDREQn <= 1'b1;
         pmu.HOLDABORT     <= 1'b0;
      end else begin
         case (state)
            s_run: begin
               if (sleep_ok) begin
                  state             <= s_hold;
                  cnt               <= 8'h00;
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b0;
               end else begin
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b1;
               end
            end
            s_hold: begin
               if (pmu.WAKEUP || !pmu.SLEEPING || dbg_on) begin
                  state             <= s_run;
                  pmu.HOLDABORT     <= 1'b1;
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b1;
               end else if (!pmu.SLEEPHOLDACKn) begin
                  state             <= s_gated;
                  pmu.HCLKEN        <= 1'b0;
                  pmu.SLEEPHOLDREQn <= 1'b0;
               end else if (cnt == hold_last) begin
                  state             <= s_run;
                  pmu.HOLDABORT     <= 1'b1;
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b1;
               end else begin
                  cnt <= cnt + 8'h01;
               end
            end
            s_gated: begin
               if (pmu.WAKEUP || dbg_on) begin
                  state             <= s_wake;
                  cnt               <= {4'h0, pmu.WAKEDLY};
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b0;
               end
            end
            s_wake: begin
               if (cnt == 8'h00) begin
                  state             <= s_run;
                  pmu.HCLKEN        <= 1'b1;
                  pmu.SLEEPHOLDREQn <= 1'b1;
               end else begin
                  cnt <= cnt - 8'h01;
               end
            end
            default: begin
               state             <= s_run;
               pmu.HCLKEN        <= 1'b1;
               pmu.SLEEPHOLDREQn <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cm0_pmu_seq.sv
// Directed bench for cm0_pmu_seq: sleep, deep sleep, timeout, debug wake, saturation, reset.
`timescale 1ns/1ps
module tb_cm0_pmu_seq;
   logic FCLK = 1'b0;
   logic PORESET;
   int   vectors = 0;
   int   miscompares = 0;

   cm0_pmu_seq_if bus ();

   cm0_pmu_seq #(.HOLDTO(15), .DBGSYNC(2)) dut (
      .FCLK    (FCLK),
      .PORESET (PORESET),
      .pmu     (bus.slave)
   );

   always #5 FCLK = ~FCLK;

   task automatic tick();
      @(posedge FCLK);
      #1;
   endtask

   task automatic test_reset();
      PORESET = 1'b1;
      bus.SLEEPING = 0; bus.SLEEPDEEP = 0; bus.GATEHCLK = 0; bus.WAKEUP = 0;
      bus.SLEEPHOLDACKn = 1; bus.WICENACK = 0; bus.CDBGPWRUPREQ = 0;
      bus.DEEPEN = 0; bus.WAKEDLY = 4'd4;
      #13;
      vectors++;
      if (bus.PMUSTATE !== 2'd0 || bus.HCLKEN !== 1'b1 || bus.SLEEPHOLDREQn !== 1'b1 ||
          bus.WICENREQ !== 1'b0 || bus.CDBGPWRUPACK !== 1'b0 || bus.GATEDCNT !== 16'h0 ||
          bus.HOLDABORT !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: state=%0d hclken=%b reqn=%b wic=%b ack=%b cnt=%0d abort=%b required 0 1 1 0 0 0 0",
                  bus.PMUSTATE, bus.HCLKEN, bus.SLEEPHOLDREQn, bus.WICENREQ,
                  bus.CDBGPWRUPACK, bus.GATEDCNT, bus.HOLDABORT);
      end
      @(negedge FCLK);
      PORESET = 1'b0;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd0) begin
         miscompares++;
         $display("FAIL idle_run: state=%0d required 0", bus.PMUSTATE);
      end
   endtask

   task automatic test_wicenreq();
      bus.DEEPEN = 1;
      #1;
      vectors++;
      if (bus.WICENREQ !== 1'b0) begin
         miscompares++;
         $display("FAIL wicenreq_delay: got %b required 0", bus.WICENREQ);
      end
      tick();
      vectors++;
      if (bus.WICENREQ !== 1'b1) begin
         miscompares++;
         $display("FAIL wicenreq_set: got %b required 1", bus.WICENREQ);
      end
      bus.DEEPEN = 0;
      tick();
      vectors++;
      if (bus.WICENREQ !== 1'b0) begin
         miscompares++;
         $display("FAIL wicenreq_clr: got %b required 0", bus.WICENREQ);
      end
   endtask

   task automatic test_normal_sleep();
      int n;
      bus.SLEEPING = 1; bus.GATEHCLK = 1; bus.SLEEPDEEP = 0; bus.WAKEDLY = 4'd4;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd1 || bus.SLEEPHOLDREQn !== 1'b0 || bus.HCLKEN !== 1'b1) begin
         miscompares++;
         $display("FAIL enter_hold: state=%0d reqn=%b hclken=%b required 1 0 1",
                  bus.PMUSTATE, bus.SLEEPHOLDREQn, bus.HCLKEN);
      end
      tick(); tick();
      bus.SLEEPHOLDACKn = 0;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd2 || bus.HCLKEN !== 1'b0 || bus.SLEEPHOLDREQn !== 1'b0) begin
         miscompares++;
         $display("FAIL enter_gated: state=%0d hclken=%b reqn=%b required 2 0 0",
                  bus.PMUSTATE, bus.HCLKEN, bus.SLEEPHOLDREQn);
      end
      tick(); tick(); tick();
      bus.WAKEUP = 1; bus.SLEEPING = 0;
      tick();
      bus.WAKEUP = 0; bus.SLEEPHOLDACKn = 1;
      n = (bus.PMUSTATE == 2'd3) ? 1 : 0;
      for (int i = 0; i < 20 && bus.PMUSTATE == 2'd3; i++) begin
         vectors++;
         if (bus.HCLKEN !== 1'b1 || bus.SLEEPHOLDREQn !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_outputs: hclken=%b reqn=%b required 1 0", bus.HCLKEN, bus.SLEEPHOLDREQn);
         end
         tick();
         if (bus.PMUSTATE == 2'd3) n++;
      end
      vectors++;
      if (n != 5) begin
         miscompares++;
         $display("FAIL wake_len: got %0d WAKE cycles required 5", n);
      end
      vectors++;
      if (bus.PMUSTATE !== 2'd0 || bus.SLEEPHOLDREQn !== 1'b1 || bus.GATEDCNT !== 16'd4 ||
          bus.HOLDABORT !== 1'b0) begin
         miscompares++;
         $display("FAIL wake_done: state=%0d reqn=%b gatedcnt=%0d abort=%b required 0 1 4 0",
                  bus.PMUSTATE, bus.SLEEPHOLDREQn, bus.GATEDCNT, bus.HOLDABORT);
      end
   endtask

   task automatic test_deep_sleep();
      bus.SLEEPING = 1; bus.GATEHCLK = 1; bus.SLEEPDEEP = 1; bus.WICENACK = 0;
      bus.WAKEDLY = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (bus.PMUSTATE !== 2'd0) begin
            miscompares++;
            $display("FAIL deep_no_ack: cycle %0d state=%0d required 0", i, bus.PMUSTATE);
         end
      end
      bus.WICENACK = 1;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd1) begin
         miscompares++;
         $display("FAIL deep_hold: state=%0d required 1", bus.PMUSTATE);
      end
      bus.SLEEPHOLDACKn = 0;
      tick();
      bus.SLEEPDEEP = 0; bus.WICENACK = 0;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd2 || bus.GATEDCNT !== 16'd5) begin
         miscompares++;
         $display("FAIL deep_gated_ignore: state=%0d gatedcnt=%0d required 2 5", bus.PMUSTATE, bus.GATEDCNT);
      end
      bus.WAKEUP = 1; bus.SLEEPING = 0;
      tick();
      bus.WAKEUP = 0; bus.SLEEPHOLDACKn = 1;
      vectors++;
      if (bus.PMUSTATE !== 2'd3) begin
         miscompares++;
         $display("FAIL wake0_enter: state=%0d required 3", bus.PMUSTATE);
      end
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd0 || bus.GATEDCNT !== 16'd6) begin
         miscompares++;
         $display("FAIL wake0_single: state=%0d gatedcnt=%0d required 0 6", bus.PMUSTATE, bus.GATEDCNT);
      end
   endtask

   task automatic test_timeout();
      int n;
      bus.SLEEPING = 1; bus.GATEHCLK = 1; bus.SLEEPDEEP = 0; bus.SLEEPHOLDACKn = 1;
      tick();
      n = 0;
      for (int i = 0; i < 40 && bus.PMUSTATE == 2'd1; i++) begin
         n++;
         tick();
      end
      bus.SLEEPING = 0;
      vectors++;
      if (n != 15 || bus.PMUSTATE !== 2'd0 || bus.HOLDABORT !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_timeout: hold cycles=%0d state=%0d abort=%b required 15 0 1",
                  n, bus.PMUSTATE, bus.HOLDABORT);
      end
      tick(); tick(); tick();
      vectors++;
      if (bus.HOLDABORT !== 1'b1 || bus.PMUSTATE !== 2'd0) begin
         miscompares++;
         $display("FAIL abort_sticky: abort=%b state=%0d required 1 0", bus.HOLDABORT, bus.PMUSTATE);
      end
   endtask

   task automatic test_debug();
      logic saw_hold;
      bus.SLEEPING = 1; bus.WAKEDLY = 4'd4;
      tick();
      bus.SLEEPHOLDACKn = 0;
      tick();
      bus.SLEEPHOLDACKn = 1;
      bus.CDBGPWRUPREQ = 1;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd3 || bus.CDBGPWRUPACK !== 1'b0) begin
         miscompares++;
         $display("FAIL dbg_wake: state=%0d ack=%b required 3 0", bus.PMUSTATE, bus.CDBGPWRUPACK);
      end
      tick();
      vectors++;
      if (bus.CDBGPWRUPACK !== 1'b1) begin
         miscompares++;
         $display("FAIL dbg_ack: got %b required 1", bus.CDBGPWRUPACK);
      end
      saw_hold = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.PMUSTATE == 2'd1) saw_hold = 1'b1;
      end
      vectors++;
      if (saw_hold !== 1'b0 || bus.PMUSTATE !== 2'd0) begin
         miscompares++;
         $display("FAIL dbg_block_hold: saw_hold=%b state=%0d required 0 0", saw_hold, bus.PMUSTATE);
      end
      bus.CDBGPWRUPREQ = 0;
      tick(); tick();
      vectors++;
      if (bus.CDBGPWRUPACK !== 1'b0 || bus.PMUSTATE !== 2'd0) begin
         miscompares++;
         $display("FAIL dbg_release: ack=%b state=%0d required 0 0", bus.CDBGPWRUPACK, bus.PMUSTATE);
      end
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd1) begin
         miscompares++;
         $display("FAIL dbg_rehold: state=%0d required 1", bus.PMUSTATE);
      end
   endtask

   task automatic test_saturation();
      bus.SLEEPHOLDACKn = 0;
      tick();
      vectors++;
      if (bus.PMUSTATE !== 2'd2) begin
         miscompares++;
         $display("FAIL sat_enter: state=%0d required 2", bus.PMUSTATE);
      end
      for (int i = 0; i < 70000; i++) tick();
      vectors++;
      if (bus.GATEDCNT !== 16'hFFFF || bus.PMUSTATE !== 2'd2) begin
         miscompares++;
         $display("FAIL gatedcnt_sat: cnt=%h state=%0d required ffff 2", bus.GATEDCNT, bus.PMUSTATE);
      end
   endtask

   task automatic test_reset_gated();
      #2;
      PORESET = 1'b1;
      #1;
      vectors++;
      if (bus.HCLKEN !== 1'b1 || bus.SLEEPHOLDREQn !== 1'b1 || bus.GATEDCNT !== 16'h0 ||
          bus.PMUSTATE !== 2'd0 || bus.HOLDABORT !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: hclken=%b reqn=%b cnt=%h state=%0d abort=%b required 1 1 0 0 0",
                  bus.HCLKEN, bus.SLEEPHOLDREQn, bus.GATEDCNT, bus.PMUSTATE, bus.HOLDABORT);
      end
      bus.SLEEPING = 0; bus.SLEEPHOLDACKn = 1;
      @(negedge FCLK);
      PORESET = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_wicenreq();
      test_normal_sleep();
      test_deep_sleep();
      test_timeout();
      test_debug();
      test_saturation();
      test_reset_gated();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
